alu_rs: RTL and testbench

Reservation station for the integer ALU in the out-of-order core. Buffers dispatched arithmetic, jump and branch instructions, tracks operand readiness by ROB tag, snoops the two CDB broadcasts for wakeup, and issues one ready instruction per cycle into the combinational ALU. It sits between dispatch (upstream) and the ALU (downstream). The ALU's CDB result feeds back into this block's snoop port.

---
 rtl/alu_rs_pkg.sv | 24 ++
 rtl/alu_rs_if.sv | 34 +++
 rtl/alu_rs_lowest_pick.sv | 20 ++
 rtl/alu_rs.sv | 198 +++++++++++++++++++
 tb/tb_alu_rs.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants and opcode encodings for the integer-ALU reservation station.
package alu_rs_pkg;

  localparam int RS_SIZE_DEF = 16;
  localparam int IDX_W_DEF   = 4;
  localparam int OP_W_DEF    = 6;
  localparam int ROB_W_DEF   = 4;
  localparam int DATA_W      = 32;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_ADDI = 6'd3,
    OP_AND  = 6'd4,
    OP_OR   = 6'd5,
    OP_XOR  = 6'd6,
    OP_BEQ  = 6'd7,
    OP_BNE  = 6'd8,
    OP_JAL  = 6'd9,
    OP_JALR = 6'd10
  } alu_op_e;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch port of the reservation station: one instruction with operand tags/values.
// Handshake: an instruction transfers on a rising edge where disEn_i=1 and full_o=0;
// disEn_i while full_o=1 is dropped, and full_o never depends on disEn_i.
interface alu_rs_if
  import alu_rs_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ROB_W = ROB_W_DEF
);
  logic              disEn_i;
  logic [OP_W-1:0]   disOpcode_i;
  logic [DATA_W-1:0] disImm_i;
  logic [DATA_W-1:0] disPc_i;
  logic [ROB_W-1:0]  disId_i;
  logic [ROB_W-1:0]  disQj_i;
  logic              disQjBusy_i;
  logic [DATA_W-1:0] disVj_i;
  logic [ROB_W-1:0]  disQk_i;
  logic              disQkBusy_i;
  logic [DATA_W-1:0] disVk_i;
  logic              full_o;

  modport master (
    output disEn_i, disOpcode_i, disImm_i, disPc_i, disId_i,
           disQj_i, disQjBusy_i, disVj_i, disQk_i, disQkBusy_i, disVk_i,
    input  full_o
  );

  modport slave (
    input  disEn_i, disOpcode_i, disImm_i, disPc_i, disId_i,
           disQj_i, disQjBusy_i, disVj_i, disQk_i, disQkBusy_i, disVk_i,
    output full_o
  );
endinterface

// File: rtl/alu_rs_lowest_pick.sv
// Find-lowest-set encoder: reports whether any request bit is set and the index of the lowest.
module rs_lowest_pick #(
  parameter int N  = 16,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Scan high to low so the last (lowest) hit wins.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer-ALU reservation station: buffers dispatched ops, wakes operands from two CDBs,
// and issues the lowest-index ready entry each cycle into registered ALU outputs.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr_i,
  alu_rs_if.slave           dis,
  input  logic              aluCdbEn_i,
  input  logic [ROB_W-1:0]  aluCdbId_i,
  input  logic [DATA_W-1:0] aluCdbData_i,
  input  logic              lsbCdbEn_i,
  input  logic [ROB_W-1:0]  lsbCdbId_i,
  input  logic [DATA_W-1:0] lsbCdbData_i,
  output logic              aluEn_o,
  output logic [OP_W-1:0]   aluOpcode_o,
  output logic [DATA_W-1:0] aluImm_o,
  output logic [DATA_W-1:0] aluPc_o,
  output logic [DATA_W-1:0] aluR1Data_o,
  output logic [DATA_W-1:0] aluR2Data_o,
  output logic [ROB_W-1:0]  aluId_o
);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qjb_q, qjb_d;
  logic [RS_SIZE-1:0] qkb_q, qkb_d;
  logic [DATA_W-1:0]  vj_q [RS_SIZE];
  logic [DATA_W-1:0]  vj_d [RS_SIZE];
  logic [DATA_W-1:0]  vk_q [RS_SIZE];
  logic [DATA_W-1:0]  vk_d [RS_SIZE];
  logic [OP_W-1:0]    op_q [RS_SIZE];
  logic [DATA_W-1:0]  imm_q [RS_SIZE];
  logic [DATA_W-1:0]  pc_q [RS_SIZE];
  logic [ROB_W-1:0]   id_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_q [RS_SIZE];
  logic [ROB_W-1:0]   qk_q [RS_SIZE];

  logic              aluEn_q;
  logic [OP_W-1:0]   aluOp_q;
  logic [DATA_W-1:0] aluImm_q, aluPc_q, aluR1_q, aluR2_q;
  logic [ROB_W-1:0]  aluId_q;

  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic               free_found, ready_found;
  logic [IDX_W-1:0]   free_idx, ready_idx;
  logic               dis_fire;
  logic [DATA_W-1:0]  dis_vj, dis_vk;
  logic               dis_qjb, dis_qkb;

  // Both pickers look only at registered state, so a slot freed by this
  // cycle's issue is not handed to this cycle's dispatch.
  assign free_vec  = ~busy_q;
  assign ready_vec = busy_q & ~qjb_q & ~qkb_q;

  rs_lowest_pick #(.N(RS_SIZE), .IW(IDX_W)) u_free_pick (
    .req_i   (free_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_lowest_pick #(.N(RS_SIZE), .IW(IDX_W)) u_ready_pick (
    .req_i   (ready_vec),
    .found_o (ready_found),
    .idx_o   (ready_idx)
  );

  assign dis.full_o = ~free_found;
  assign dis_fire   = dis.disEn_i & free_found;

  // Operands still pending at dispatch may be satisfied by a same-cycle broadcast.
  always_comb begin
    dis_vj  = dis.disVj_i;
    dis_qjb = dis.disQjBusy_i;
    dis_vk  = dis.disVk_i;
    dis_qkb = dis.disQkBusy_i;
    if (dis.disQjBusy_i) begin
      if (aluCdbEn_i && aluCdbId_i == dis.disQj_i) begin
        dis_vj  = aluCdbData_i;
        dis_qjb = 1'b0;
      end else if (lsbCdbEn_i && lsbCdbId_i == dis.disQj_i) begin
        dis_vj  = lsbCdbData_i;
        dis_qjb = 1'b0;
      end
    end
    if (dis.disQkBusy_i) begin
      if (aluCdbEn_i && aluCdbId_i == dis.disQk_i) begin
        dis_vk  = aluCdbData_i;
        dis_qkb = 1'b0;
      end else if (lsbCdbEn_i && lsbCdbId_i == dis.disQk_i) begin
        dis_vk  = lsbCdbData_i;
        dis_qkb = 1'b0;
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    qjb_d  = qjb_q;
    qkb_d  = qkb_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      vj_d[i] = vj_q[i];
      vk_d[i] = vk_q[i];
      if (busy_q[i] && qjb_q[i]) begin
        if (aluCdbEn_i && aluCdbId_i == qj_q[i]) begin
          vj_d[i]  = aluCdbData_i;
          qjb_d[i] = 1'b0;
        end else if (lsbCdbEn_i && lsbCdbId_i == qj_q[i]) begin
          vj_d[i]  = lsbCdbData_i;
          qjb_d[i] = 1'b0;
        end
      end
      if (busy_q[i] && qkb_q[i]) begin
        if (aluCdbEn_i && aluCdbId_i == qk_q[i]) begin
          vk_d[i]  = aluCdbData_i;
          qkb_d[i] = 1'b0;
        end else if (lsbCdbEn_i && lsbCdbId_i == qk_q[i]) begin
          vk_d[i]  = lsbCdbData_i;
          qkb_d[i] = 1'b0;
        end
      end
    end
    if (ready_found) busy_d[ready_idx] = 1'b0;
    if (dis_fire) begin
      busy_d[free_idx] = 1'b1;
      qjb_d[free_idx]  = dis_qjb;
      qkb_d[free_idx]  = dis_qkb;
      vj_d[free_idx]   = dis_vj;
      vk_d[free_idx]   = dis_vk;
    end
    if (clr_i) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      qjb_q    <= '0;
      qkb_q    <= '0;
      aluEn_q  <= 1'b0;
      aluOp_q  <= '0;
      aluImm_q <= '0;
      aluPc_q  <= '0;
      aluR1_q  <= '0;
      aluR2_q  <= '0;
      aluId_q  <= '0;
    end else if (rdy) begin
      busy_q <= busy_d;
      qjb_q  <= qjb_d;
      qkb_q  <= qkb_d;
      if (clr_i) begin
        aluEn_q <= 1'b0;
      end else if (ready_found) begin
        aluEn_q  <= 1'b1;
        aluOp_q  <= op_q[ready_idx];
        aluImm_q <= imm_q[ready_idx];
        aluPc_q  <= pc_q[ready_idx];
        aluR1_q  <= vj_q[ready_idx];
        aluR2_q  <= vk_q[ready_idx];
        aluId_q  <= id_q[ready_idx];
      end else begin
        aluEn_q <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while busy is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        vj_q[i] <= vj_d[i];
        vk_q[i] <= vk_d[i];
      end
      if (dis_fire) begin
        op_q[free_idx]  <= dis.disOpcode_i;
        imm_q[free_idx] <= dis.disImm_i;
        pc_q[free_idx]  <= dis.disPc_i;
        id_q[free_idx]  <= dis.disId_i;
        qj_q[free_idx]  <= dis.disQj_i;
        qk_q[free_idx]  <= dis.disQk_i;
      end
    end
  end

  assign aluEn_o     = aluEn_q;
  assign aluOpcode_o = aluOp_q;
  assign aluImm_o    = aluImm_q;
  assign aluPc_o     = aluPc_q;
  assign aluR1Data_o = aluR1_q;
  assign aluR2Data_o = aluR2_q;
  assign aluId_o     = aluId_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: vector table through a scoreboard, then timing corner cases.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        rst, rdy, clr_i;
  logic        aluCdbEn_i, lsbCdbEn_i;
  logic [3:0]  aluCdbId_i, lsbCdbId_i;
  logic [31:0] aluCdbData_i, lsbCdbData_i;
  logic        aluEn_o;
  logic [5:0]  aluOpcode_o;
  logic [31:0] aluImm_o, aluPc_o, aluR1Data_o, aluR2Data_o;
  logic [3:0]  aluId_o;

  alu_rs_if dis_if ();

  alu_rs u_dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .clr_i        (clr_i),
    .dis          (dis_if),
    .aluCdbEn_i   (aluCdbEn_i),
    .aluCdbId_i   (aluCdbId_i),
    .aluCdbData_i (aluCdbData_i),
    .lsbCdbEn_i   (lsbCdbEn_i),
    .lsbCdbId_i   (lsbCdbId_i),
    .lsbCdbData_i (lsbCdbData_i),
    .aluEn_o      (aluEn_o),
    .aluOpcode_o  (aluOpcode_o),
    .aluImm_o     (aluImm_o),
    .aluPc_o      (aluPc_o),
    .aluR1Data_o  (aluR1Data_o),
    .aluR2Data_o  (aluR2Data_o),
    .aluId_o      (aluId_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [5:0]  op;
    logic [3:0]  id;
    logic [31:0] imm, pc;
    logic [3:0]  qj, qk;
    logic        qjb, qkb;
    logic [31:0] vj, vk;
    logic [1:0]  cdb_sel;   // 0 none, 1 ALU CDB, 2 LSB CDB
    logic [3:0]  cdb_id;
    logic [31:0] cdb_d;
    logic [31:0] exp_r1, exp_r2;
  } vec_t;

  vec_t vt [NV];

  logic [137:0] exp_q [$];
  logic         sb_on = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  function automatic logic [137:0] pack_issue(logic [3:0] id, logic [5:0] op, logic [31:0] imm,
                                              logic [31:0] pc, logic [31:0] r1, logic [31:0] r2);
    return {id, op, imm, pc, r1, r2};
  endfunction

  task automatic chk(input string nm, input logic [137:0] act, input logic [137:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (sb_on && aluEn_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_issue: got id %0h expected no issue", aluId_o);
      end else begin
        logic [137:0] e;
        logic [137:0] a;
        e = exp_q.pop_front();
        a = pack_issue(aluId_o, aluOpcode_o, aluImm_o, aluPc_o, aluR1Data_o, aluR2Data_o);
        if (a !== e) begin
          n_err++;
          $display("FAIL sb_issue: got %0h expected %0h", a, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dis_set(input logic [5:0] op, input logic [3:0] id, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] qj, input logic qjb,
                         input logic [31:0] vj, input logic [3:0] qk, input logic qkb,
                         input logic [31:0] vk);
    dis_if.disEn_i     = 1'b1;
    dis_if.disOpcode_i = op;
    dis_if.disId_i     = id;
    dis_if.disImm_i    = imm;
    dis_if.disPc_i     = pc;
    dis_if.disQj_i     = qj;
    dis_if.disQjBusy_i = qjb;
    dis_if.disVj_i     = vj;
    dis_if.disQk_i     = qk;
    dis_if.disQkBusy_i = qkb;
    dis_if.disVk_i     = vk;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [3:0] id, input logic [31:0] imm,
                          input logic [31:0] pc, input logic [3:0] qj, input logic qjb,
                          input logic [31:0] vj, input logic [3:0] qk, input logic qkb,
                          input logic [31:0] vk);
    dis_set(op, id, imm, pc, qj, qjb, vj, qk, qkb, vk);
    step();
    dis_if.disEn_i = 1'b0;
  endtask

  task automatic cdb_off();
    aluCdbEn_i = 1'b0;
    lsbCdbEn_i = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1'b0; rdy = 1'b1; clr_i = 1'b0;
    cdb_off();
    aluCdbId_i = '0; aluCdbData_i = '0; lsbCdbId_i = '0; lsbCdbData_i = '0;
    dis_set(6'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0);
    dis_if.disEn_i = 1'b0;

    repeat (2) step();
    chk("reset_en", aluEn_o, 0);
    chk("reset_id", aluId_o, 0);
    chk("reset_r1", aluR1Data_o, 0);
    chk("reset_full", dis_if.full_o, 0);
    rst = 1'b1;
    step();

    // Table: fixed cases then random ready dispatches.
    vt[0] = '{OP_ADDI, 4'd3, 32'd7, 32'h100, 4'd0, 4'd0, 1'b0, 1'b0, 32'd5, 32'd0,
              2'd0, 4'd0, 32'd0, 32'd5, 32'd0};
    vt[1] = '{OP_ADD, 4'd4, 32'd0, 32'h104, 4'd1, 4'd2, 1'b0, 1'b0, 32'h11, 32'h22,
              2'd0, 4'd0, 32'd0, 32'h11, 32'h22};
    vt[2] = '{OP_SUB, 4'd7, 32'd0, 32'h108, 4'd0, 4'd6, 1'b0, 1'b1, 32'h9, 32'hDEAD,
              2'd1, 4'd6, 32'hAB, 32'h9, 32'hAB};
    vt[3] = '{OP_XOR, 4'd8, 32'd0, 32'h10C, 4'd1, 4'd0, 1'b1, 1'b0, 32'hBEEF, 32'h3,
              2'd2, 4'd1, 32'h1234, 32'h1234, 32'h3};
    vt[4] = '{OP_BEQ, 4'd9, 32'hFFFF_FFF0, 32'h110, 4'd2, 4'd2, 1'b1, 1'b1, 32'd0, 32'd0,
              2'd1, 4'd2, 32'h55, 32'h55, 32'h55};
    for (int i = 5; i < NV; i++) begin
      vt[i].op      = 6'($urandom_range(0, 10));
      vt[i].id      = 4'($urandom_range(0, 15));
      vt[i].imm     = $urandom;
      vt[i].pc      = $urandom;
      vt[i].qj      = 4'($urandom_range(0, 15));
      vt[i].qk      = 4'($urandom_range(0, 15));
      vt[i].qjb     = 1'b0;
      vt[i].qkb     = 1'b0;
      vt[i].vj      = $urandom;
      vt[i].vk      = $urandom;
      vt[i].cdb_sel = 2'd0;
      vt[i].cdb_id  = 4'd0;
      vt[i].cdb_d   = 32'd0;
      vt[i].exp_r1  = vt[i].vj;
      vt[i].exp_r2  = vt[i].vk;
    end

    sb_on = 1'b1;
    for (int i = 0; i < NV; i++) begin
      dis_set(vt[i].op, vt[i].id, vt[i].imm, vt[i].pc, vt[i].qj, vt[i].qjb, vt[i].vj,
              vt[i].qk, vt[i].qkb, vt[i].vk);
      aluCdbEn_i = (vt[i].cdb_sel == 2'd1);
      aluCdbId_i = vt[i].cdb_id;
      aluCdbData_i = vt[i].cdb_d;
      lsbCdbEn_i = (vt[i].cdb_sel == 2'd2);
      lsbCdbId_i = vt[i].cdb_id;
      lsbCdbData_i = vt[i].cdb_d;
      exp_q.push_back(pack_issue(vt[i].id, vt[i].op, vt[i].imm, vt[i].pc,
                                 vt[i].exp_r1, vt[i].exp_r2));
      step();
      cdb_off();
    end
    dis_if.disEn_i = 1'b0;
    repeat (4) step();
    chk("sb_drain", exp_q.size(), 0);
    sb_on = 1'b0;

    // Ready dispatch: two-edge latency, one-cycle pulse.
    dispatch(OP_ADDI, 4'd3, 32'd7, 32'h200, 4'd0, 1'b0, 32'd5, 4'd0, 1'b0, 32'd0);
    @(negedge clk); chk("rdy_lat1_en", aluEn_o, 0);
    @(negedge clk); chk("rdy_en", aluEn_o, 1);
    chk("rdy_id", aluId_o, 3);
    chk("rdy_r1", aluR1Data_o, 5);
    chk("rdy_imm", aluImm_o, 7);
    @(negedge clk); chk("rdy_pulse_end", aluEn_o, 0);

    // Wakeup from the LSB CDB.
    step();
    dispatch(OP_ADD, 4'd4, 32'd0, 32'h204, 4'd2, 1'b1, 32'd0, 4'd0, 1'b0, 32'd3);
    step(); step();
    @(negedge clk); chk("wk_wait_en", aluEn_o, 0);
    lsbCdbEn_i = 1'b1; lsbCdbId_i = 4'd2; lsbCdbData_i = 32'h10;
    step();
    cdb_off();
    @(negedge clk); chk("wk_lat1_en", aluEn_o, 0);
    @(negedge clk); chk("wk_en", aluEn_o, 1);
    chk("wk_id", aluId_o, 4);
    chk("wk_r1", aluR1Data_o, 32'h10);
    chk("wk_r2", aluR2Data_o, 32'd3);
    @(negedge clk); chk("wk_pulse_end", aluEn_o, 0);

    // Same-cycle forwarding from the ALU CDB.
    step();
    aluCdbEn_i = 1'b1; aluCdbId_i = 4'd6; aluCdbData_i = 32'hAB;
    dispatch(OP_SUB, 4'd8, 32'd0, 32'h208, 4'd0, 1'b0, 32'd1, 4'd6, 1'b1, 32'd0);
    cdb_off();
    @(negedge clk); chk("fwd_lat1_en", aluEn_o, 0);
    @(negedge clk); chk("fwd_en", aluEn_o, 1);
    chk("fwd_r2", aluR2Data_o, 32'hAB);
    chk("fwd_id", aluId_o, 8);

    // Fill all 16 entries with pending operands, then overflow.
    step();
    for (int i = 0; i < 16; i++)
      dispatch(OP_ADD, 4'(i), 32'(i), 32'(i * 4), 4'(i), 1'b1, 32'd0, 4'd0, 1'b0, 32'(i));
    @(negedge clk); chk("full_set", dis_if.full_o, 1);
    chk("full_no_issue", aluEn_o, 0);
    step();
    dispatch(OP_ADDI, 4'd13, 32'd1, 32'h300, 4'd0, 1'b0, 32'd1, 4'd0, 1'b0, 32'd0);
    repeat (3) begin
      @(negedge clk); chk("overflow_dropped", aluEn_o, 0);
    end
    chk("full_hold", dis_if.full_o, 1);
    step();
    aluCdbEn_i = 1'b1; aluCdbId_i = 4'd9; aluCdbData_i = 32'h99;
    lsbCdbEn_i = 1'b1; lsbCdbId_i = 4'd3; lsbCdbData_i = 32'h33;
    step();
    cdb_off();
    @(negedge clk); chk("pri_lat1_en", aluEn_o, 0);
    chk("pri_full_during_issue", dis_if.full_o, 1);
    @(negedge clk); chk("pri_first_en", aluEn_o, 1);
    chk("pri_first_id", aluId_o, 3);
    chk("pri_first_r1", aluR1Data_o, 32'h33);
    chk("pri_full_after", dis_if.full_o, 0);
    @(negedge clk); chk("pri_second_en", aluEn_o, 1);
    chk("pri_second_id", aluId_o, 9);
    chk("pri_second_r1", aluR1Data_o, 32'h99);
    @(negedge clk); chk("pri_end", aluEn_o, 0);

    // Flush while a ready entry is about to issue.
    step();
    dispatch(OP_ADDI, 4'd12, 32'd2, 32'h400, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 32'd0);
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    @(negedge clk); chk("flush_en", aluEn_o, 0);
    chk("flush_full", dis_if.full_o, 0);
    for (int t = 0; t < 16; t++) begin
      aluCdbEn_i = 1'b1; aluCdbId_i = 4'(t); aluCdbData_i = 32'(t);
      step();
      cdb_off();
      @(negedge clk); chk("flush_gone", aluEn_o, 0);
    end

    // Freeze with rdy=0: outputs hold and a broadcast is not captured.
    step();
    dispatch(OP_ADD, 4'd11, 32'd0, 32'h500, 4'd7, 1'b1, 32'd0, 4'd0, 1'b0, 32'd4);
    dispatch(OP_ADDI, 4'd5, 32'd1, 32'h504, 4'd0, 1'b0, 32'h50, 4'd0, 1'b0, 32'd0);
    @(negedge clk); chk("frz_pre_en", aluEn_o, 0);
    step();
    rdy = 1'b0;
    lsbCdbEn_i = 1'b1; lsbCdbId_i = 4'd7; lsbCdbData_i = 32'h77;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk); chk("frz_hold_en", aluEn_o, 1);
      chk("frz_hold_id", aluId_o, 5);
      chk("frz_hold_r1", aluR1Data_o, 32'h50);
    end
    rdy = 1'b1;
    cdb_off();
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk); chk("frz_not_captured", aluEn_o, 0);
    end
    lsbCdbEn_i = 1'b1; lsbCdbId_i = 4'd7; lsbCdbData_i = 32'h70;
    step();
    cdb_off();
    @(negedge clk); chk("frz_wk_lat1", aluEn_o, 0);
    @(negedge clk); chk("frz_wk_en", aluEn_o, 1);
    chk("frz_wk_id", aluId_o, 11);
    chk("frz_wk_r1", aluR1Data_o, 32'h70);

    // Asynchronous reset mid-run with 5 busy entries.
    step();
    for (int i = 0; i < 5; i++)
      dispatch(OP_OR, 4'(i), 32'd0, 32'h600, 4'(i), 1'b1, 32'd0, 4'd0, 1'b0, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_en", aluEn_o, 0);
    chk("arst_id", aluId_o, 0);
    chk("arst_op", aluOpcode_o, 0);
    chk("arst_r1", aluR1Data_o, 0);
    chk("arst_full", dis_if.full_o, 0);
    #2;
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step();
      aluCdbEn_i = 1'b1; aluCdbId_i = 4'(t); aluCdbData_i = 32'hC0 + 32'(t);
    end
    step();
    cdb_off();
    repeat (3) begin
      @(negedge clk); chk("arst_no_issue", aluEn_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
